// File: rtl/alu_op_sequencer_if.sv
// Command channel into the ALU op sequencer: valid/ready handshake plus the decoded command fields.
interface alu_op_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic              cmd_ldi;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic [ADDR_W-1:0] cmd_dst;
  logic [DATA_W-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_ldi, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ldi, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences register-file reads, one ALU operation and a writeback per command (6-cycle throughput).
// Optional load-immediate path enabled by defining ALU_OP_SEQUENCER_LDI_EN.
module alu_op_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave cmd,
  output logic [ADDR_W-1:0] address,
  output logic              read_enable,
  output logic              write_enable,
  output logic [DATA_W-1:0] data_input,
  input  logic [DATA_W-1:0] output_data,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [1:0]        alu_function_select,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flag_registers,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A    = 3'd1,
    RD_B    = 3'd2,
    LATCH_B = 3'd3,
    EXEC    = 3'd4,
    WB      = 3'd5
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] opa_q;

  assign cmd.cmd_ready = (state == IDLE) && !rst;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      op_q                <= 2'b00;
      src_b_q             <= '0;
      dst_q               <= '0;
      opa_q               <= '0;
      address             <= '0;
      read_enable         <= 1'b0;
      write_enable        <= 1'b0;
      data_input          <= '0;
      alu_operand_a       <= '0;
      alu_operand_b       <= '0;
      alu_function_select <= 2'b00;
      flag_registers      <= 4'b0000;
      done                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            op_q    <= cmd.cmd_op;
            src_b_q <= cmd.cmd_src_b;
            dst_q   <= cmd.cmd_dst;
`ifdef ALU_OP_SEQUENCER_LDI_EN
            if (cmd.cmd_ldi) begin
              address      <= cmd.cmd_dst;
              data_input   <= cmd.cmd_imm;
              write_enable <= 1'b1;
              done         <= 1'b1;
              state        <= WB;
            end else begin
              address     <= cmd.cmd_src_a;
              read_enable <= 1'b1;
              state       <= RD_A;
            end
`else
            address     <= cmd.cmd_src_a;
            read_enable <= 1'b1;
            state       <= RD_A;
`endif
          end
        end
        RD_A: begin
          address     <= src_b_q;
          read_enable <= 1'b1;
          state       <= RD_B;
        end
        RD_B: begin
          // memory returns src_a data one cycle after its read strobe
          opa_q       <= output_data;
          read_enable <= 1'b0;
          state       <= LATCH_B;
        end
        LATCH_B: begin
          alu_operand_a       <= opa_q;
          alu_operand_b       <= output_data;
          alu_function_select <= op_q;
          state               <= EXEC;
        end
        EXEC: begin
          data_input     <= alu_result;
          flag_registers <= alu_flags;
          address        <= dst_q;
          write_enable   <= 1'b1;
          done           <= 1'b1;
          state          <= WB;
        end
        WB: begin
          write_enable <= 1'b0;
          done         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          read_enable  <= 1'b0;
          write_enable <= 1'b0;
          done         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-file address width (32 registers).
REQ-002 SHALL have parameter DATA_W, default 8, register and ALU data width.
REQ-003 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  synchronous active-high reset.
REQ-005 SHALL have cmd_valid  input  1  command offered.
REQ-006 SHALL have cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have cmd_op  input  2  alu_function_select code (00 ADD, 01 SUB, 10 AND, 11 OR).
REQ-008 SHALL have cmd_ldi  input  1  load-immediate command (see Configuration).
REQ-009 SHALL have cmd_src_a, cmd_src_b, cmd_dst  input  ADDR_W each  operand and destination register addresses.
REQ-010 SHALL have cmd_imm  input  DATA_W  immediate for load-immediate.
REQ-011 SHALL have address  output  ADDR_W, read_enable  output  1, write_enable  output  1, data_input  output  DATA_W  MemoryUnit port drive.
REQ-012 SHALL have output_data  input  DATA_W  MemoryUnit read data, valid the cycle after read_enable.
REQ-013 SHALL have alu_operand_a, alu_operand_b  output  DATA_W, alu_function_select  output  2  ALU drive.
REQ-014 SHALL have alu_result  input  DATA_W, alu_flags  input  4  combinational ALU response.
REQ-015 SHALL have flag_registers  output  4, busy  output  1, done  output  1  status.

Function
REQ-016 SHALL implement states IDLE, RD_A, RD_B, LATCH_B, EXEC, WB.
REQ-017 cmd_ready SHALL equal (state==IDLE) and not rst; a command is accepted on cmd_valid && cmd_ready; all cmd_* fields latched at acceptance, later input changes ignored.
REQ-018 ALU command path: IDLE->RD_A->RD_B->LATCH_B->EXEC->WB->IDLE, one cycle per state, no stalls.
REQ-019 RD_A: address=src_a, read_enable=1. RD_B: address=src_b, read_enable=1, operand A latched from output_data. LATCH_B: read_enable=0, operand B latched from output_data.
REQ-020 EXEC: alu_operand_a/b and alu_function_select driven from latched values; alu_result latched and flag_registers loaded from alu_flags at end of EXEC.
REQ-021 WB: address=dst, data_input=latched result, write_enable=1 for exactly one cycle; done=1 in the same cycle.
REQ-022 ALU command latency: done asserted 5 cycles after the accepting edge; next command accepted no earlier than the cycle after WB (6-cycle throughput).
REQ-023 read_enable and write_enable SHALL never be high in the same cycle; outside RD_A/RD_B both read_enable=0 and outside WB write_enable=0.
REQ-024 dst equal to src_a or src_b (including src_a==src_b==dst) SHALL be legal; operands are read before writeback, result overwrites the register.
REQ-025 busy SHALL equal (state!=IDLE); flag_registers hold their value between EXEC cycles, unchanged by load-immediate.
REQ-026 In IDLE address, data_input, alu_operand_a/b SHALL hold last values; only enables are forced low.

Reset
REQ-027 rst SHALL force state=IDLE, cmd_ready=1 (after release), busy=0, done=0, read_enable=0, write_enable=0, address=0, data_input=0, alu_operand_a/b=0, alu_function_select=00, flag_registers=0000.
REQ-028 rst asserted mid-command SHALL abort it with no write_enable pulse; the command is lost, not replayed.
REQ-029 rst takes priority over cmd_valid in the same cycle.

Configuration
REQ-030 Macro ALU_OP_SEQUENCER_LDI_EN: defined -> accepted command with cmd_ldi=1 goes IDLE->WB->IDLE, writing cmd_imm to cmd_dst, done 1 cycle after acceptance, no reads, flags untouched.
REQ-031 Macro undefined -> cmd_ldi ignored, every command follows the ALU path; port still present.

Verification
REQ-032 LDI_EN defined: LDI 141 (0x8D)->R4, LDI 208 (0xD0)->R6, LDI 32 (0x20)->R8 back-to-back -> three single write_enable pulses at addresses 4, 6, 8 with data 8D, D0, 20; done each 1 cycle after acceptance.
REQ-033 Memory model holds R4=0x8D, R6=0xD0; ADD src_a=4, src_b=6, dst=10 -> reads at 4 then 6, alu_operand_a=8D, alu_operand_b=D0, write 0x5D to address 10 exactly 5 cycles after acceptance, flag_registers = ALU model flags.
REQ-034 cmd_valid held high during busy with changing fields -> cmd_ready=0, no second acceptance until IDLE, first command's fields used unchanged.
REQ-035 SUB src_a=src_b=dst=4 with R4=0x8D -> R4 written 0x00, flags loaded at EXEC.
REQ-036 rst pulsed during LATCH_B of an ADD -> no write_enable, all outputs at reset values next cycle, a new command accepted the cycle after rst deasserts.
REQ-037 LDI_EN undefined: cmd_ldi=1, op=AND, src 4/6, dst 8 -> full ALU path, write 0x80 to address 8.
